// File: rtl/mem_load_arb.sv
// mem_load_arb: data-port arbiter and serial program loader for the unified memory.
// In IDLE the CPU data port passes straight through to the memory. A load session
// takes the port over, holds the core in reset, packs big-endian bytes into words,
// writes them to consecutive word addresses and then releases the core.
module mem_load_arb #(
    parameter int          LOAD_WORDS  = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RELEASE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_start,
    input  logic [7:0]  ld_byte_i,
    input  logic        ld_byte_vld,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_dout_i,
    input  logic [3:0]  core_wr_en_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_din_o,
    output logic [3:0]  mem_wr_en_o,
    output logic        core_rst_o,
    output logic        ld_busy_o,
    output logic        ld_done_o,
    output logic [15:0] ld_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(LOAD_WORDS - 1);
    localparam logic [7:0]  REL_INIT = 8'(RELEASE_CYC);

    state_t      state_q, state_d;
    logic [31:0] asm_q, asm_d;     // byte assembly register
    logic [31:0] wr_q, wr_d;       // completed word awaiting / after its write
    logic [31:0] addr_q, addr_d;   // last load address, held between writes
    logic [1:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rel_q, rel_d;
    logic        core_rst_q, core_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] wr_addr;
    logic [31:0] next_asm;

    assign wr_addr  = BASE_ADDR + {14'd0, cnt_q, 2'b00};
    assign next_asm = {asm_q[23:0], ld_byte_i};

    // Next-state logic for the load session: byte packing, word writes, release countdown.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        asm_d   = asm_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = 16'd0;
                    idx_d   = 2'd0;
                    pend_d  = 1'b0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_LOAD: begin
                // The pending word is on the bus this cycle; retire it at the edge.
                if (pend_q) begin
                    pend_d = 1'b0;
                    cnt_d  = cnt_q + 16'd1;
                    addr_d = wr_addr;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_RELEASE;
                        rel_d   = REL_INIT;
                    end
                end
                // Assembly runs independently of the write, so a byte in a write cycle is kept.
                if (ld_byte_vld) begin
                    asm_d = next_asm;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wr_d   = next_asm;
                        pend_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                rel_d = rel_q - 8'd1;
                if (rel_q == 8'd1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        core_rst_d = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and registered status outputs; all session state clears on system reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            asm_q      <= '0;
            wr_q       <= '0;
            addr_q     <= BASE_ADDR;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            rel_q      <= '0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            asm_q      <= asm_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            rel_q      <= rel_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Memory port mux: zero-latency passthrough in IDLE, loader owns the port otherwise.
    always_comb begin
        mem_addr_o  = core_addr_i;
        mem_din_o   = core_dout_i;
        mem_wr_en_o = core_wr_en_i;
        if (state_q != ST_IDLE) begin
            mem_din_o   = wr_q;
            mem_addr_o  = pend_q ? wr_addr : addr_q;
            mem_wr_en_o = pend_q ? 4'hF : 4'h0;
        end
    end

    assign core_rst_o = core_rst_q;
    assign ld_busy_o  = busy_q;
    assign ld_done_o  = done_q;
    assign ld_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mem_load_arb.sv
// Directed bench for mem_load_arb with a queue-based reference model and
// per-cycle output comparison, plus literal checks on the write log.
module tb_mem_load_arb;

    localparam int          LW   = 2;
    localparam int          RC   = 4;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic [7:0]  ld_byte_i;
    logic        ld_byte_vld;
    logic [31:0] core_addr_i;
    logic [31:0] core_dout_i;
    logic [3:0]  core_wr_en_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_din_o;
    logic [3:0]  mem_wr_en_o;
    logic        core_rst_o;
    logic        ld_busy_o;
    logic        ld_done_o;
    logic [15:0] ld_cnt_o;

    mem_load_arb #(.LOAD_WORDS(LW), .BASE_ADDR(BASE), .RELEASE_CYC(RC)) dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_byte_i(ld_byte_i),
        .ld_byte_vld(ld_byte_vld), .core_addr_i(core_addr_i), .core_dout_i(core_dout_i),
        .core_wr_en_i(core_wr_en_i), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
        .mem_wr_en_o(mem_wr_en_o), .core_rst_o(core_rst_o), .ld_busy_o(ld_busy_o),
        .ld_done_o(ld_done_o), .ld_cnt_o(ld_cnt_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = core owns the port, 1 = collecting bytes, 2 = counting down release
    int          m_mode;
    logic [7:0]  m_bytes[$];
    bit          m_due;        // a finished word is on the bus this cycle
    logic [31:0] m_word;
    int          m_cnt;
    int          m_rel;
    bit          m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_bytes.delete(); m_due = 0; m_word = 0;
            m_cnt = 0; m_rel = 0; m_done = 0;
        end else begin
            m_done = 0;
            case (m_mode)
                0: if (ld_start) begin
                    m_mode = 1; m_cnt = 0; m_due = 0; m_bytes.delete();
                end
                1: begin
                    if (m_due) begin
                        m_due = 0;
                        m_cnt = m_cnt + 1;
                        if (m_cnt == LW) begin
                            m_mode = 2;
                            m_rel  = RC;
                        end
                    end
                    if (ld_byte_vld) begin
                        m_bytes.push_back(ld_byte_i);
                        if (m_bytes.size() == 4) begin
                            m_word = (32'(m_bytes[0]) << 24) + (32'(m_bytes[1]) << 16)
                                   + (32'(m_bytes[2]) << 8) + 32'(m_bytes[3]);
                            m_due  = 1;
                            m_bytes.delete();
                        end
                    end
                end
                default: begin
                    m_rel = m_rel - 1;
                    if (m_rel == 0) begin
                        m_mode = 0;
                        m_done = 1;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          done_seen;
    int          rst_after_wr;

    always @(negedge clk) begin
        if (m_mode == 0) begin
            check("pass_addr", mem_addr_o, core_addr_i);
            check("pass_din", mem_din_o, core_dout_i);
            check("pass_wren", {28'd0, mem_wr_en_o}, {28'd0, core_wr_en_i});
        end else begin
            check("ld_wren", {28'd0, mem_wr_en_o}, m_due ? 32'hF : 32'h0);
            check("ld_din", mem_din_o, m_word);
            if (m_due) check("ld_addr", mem_addr_o, BASE + 32'(4 * m_cnt));
        end
        check("core_rst", {31'd0, core_rst_o}, {31'd0, m_mode != 0});
        check("busy", {31'd0, ld_busy_o}, {31'd0, m_mode != 0});
        check("done", {31'd0, ld_done_o}, {31'd0, m_done});
        check("cnt", {16'd0, ld_cnt_o}, 32'(m_cnt));

        if (m_mode != 0 && mem_wr_en_o == 4'hF) begin
            log_addr.push_back(mem_addr_o);
            log_data.push_back(mem_din_o);
            rst_after_wr = 0;
        end else if (core_rst_o) begin
            rst_after_wr++;
        end
        if (ld_done_o) done_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_core();
        core_addr_i  = $urandom;
        core_dout_i  = $urandom;
        core_wr_en_i = 4'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        ld_byte_i   = b;
        ld_byte_vld = 1'b1;
        scramble_core();
        tick();
        ld_byte_vld = 1'b0;
        repeat (gap) begin
            scramble_core();
            tick();
        end
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (ld_busy_o && k < 100) begin
            tick();
            k++;
        end
        check("session_ends", {31'd0, ld_busy_o}, 32'd0);
    endtask

    task automatic new_session();
        log_addr.delete();
        log_data.delete();
        done_seen    = 0;
        rst_after_wr = 0;
    endtask

    logic [7:0] s1[8];
    logic [7:0] s2[8];
    logic [7:0] s4[6];

    initial begin
        s1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        s2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        s4 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        done_seen = 0;
        rst_after_wr = 0;

        rst = 1'b0; ld_start = 1'b0; ld_byte_i = 8'h00; ld_byte_vld = 1'b0;
        core_addr_i = '0; core_dout_i = '0; core_wr_en_i = '0;

        // Reset with random core inputs (loader requests ignored under reset).
        for (int i = 0; i < 6; i++) begin
            scramble_core();
            ld_start = i[0];
            ld_byte_vld = 1'b1;
            #3;
            check("rst_wren_track", {28'd0, mem_wr_en_o}, {28'd0, core_wr_en_i});
            check("rst_core_rst", {31'd0, core_rst_o}, 32'd0);
            check("rst_cnt", {16'd0, ld_cnt_o}, 32'd0);
            tick();
        end
        core_wr_en_i = 4'h0;
        #1;
        check("rst_no_write", {28'd0, mem_wr_en_o}, 32'd0);
        ld_start = 1'b0; ld_byte_vld = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Passthrough in IDLE.
        core_addr_i = 32'h0000_0100; core_dout_i = 32'hDEAD_BEEF; core_wr_en_i = 4'b0011;
        #1;
        check("pt_addr", mem_addr_o, 32'h0000_0100);
        check("pt_din", mem_din_o, 32'hDEAD_BEEF);
        check("pt_wren", {28'd0, mem_wr_en_o}, 32'h3);
        check("pt_core_rst", {31'd0, core_rst_o}, 32'd0);
        tick();

        // Session 1: bytes spaced 3 cycles apart.
        new_session();
        pulse_start();
        foreach (s1[i]) send_byte(s1[i], 2);
        wait_idle();
        repeat (3) tick();
        check("s1_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("s1_a0", log_addr[0], 32'h0);
            check("s1_d0", log_data[0], 32'h1234_5678);
            check("s1_a1", log_addr[1], 32'h4);
            check("s1_d1", log_data[1], 32'h9ABC_DEF0);
        end
        check("s1_release_len", rst_after_wr, 4);
        check("s1_done_pulses", done_seen, 1);
        check("s1_cnt", {16'd0, ld_cnt_o}, 32'd2);

        // Session 2: back-to-back bytes, 5th byte lands in the first write cycle.
        new_session();
        pulse_start();
        foreach (s2[i]) send_byte(s2[i], 0);
        wait_idle();
        repeat (2) tick();
        check("s2_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("s2_d0", log_data[0], 32'h1122_3344);
            check("s2_a1", log_addr[1], 32'h4);
            check("s2_d1", log_data[1], 32'h5566_7788);
        end
        check("s2_done_pulses", done_seen, 1);

        // Session 3: ld_start re-pulsed mid-load is ignored.
        new_session();
        pulse_start();
        send_byte(8'hC0, 1);
        send_byte(8'hC1, 1);
        pulse_start();
        send_byte(8'hC2, 1);
        send_byte(8'hC3, 1);
        send_byte(8'hC4, 0);
        pulse_start();
        send_byte(8'hC5, 0);
        send_byte(8'hC6, 0);
        send_byte(8'hC7, 0);
        wait_idle();
        repeat (2) tick();
        check("s3_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("s3_a0", log_addr[0], 32'h0);
            check("s3_d0", log_data[0], 32'hC0C1_C2C3);
            check("s3_a1", log_addr[1], 32'h4);
            check("s3_d1", log_data[1], 32'hC4C5_C6C7);
        end
        check("s3_cnt", {16'd0, ld_cnt_o}, 32'd2);
        check("s3_done_pulses", done_seen, 1);

        // Session 4: reset after 6 bytes discards the partial word.
        new_session();
        pulse_start();
        foreach (s4[i]) send_byte(s4[i], 0);
        tick();
        rst = 1'b0;
        #2;
        check("r4_core_rst", {31'd0, core_rst_o}, 32'd0);
        check("r4_busy", {31'd0, ld_busy_o}, 32'd0);
        check("r4_cnt", {16'd0, ld_cnt_o}, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (6) tick();
        check("r4_nwrites", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check("r4_a0", log_addr[0], 32'h0);
            check("r4_d0", log_data[0], 32'hA1A2_A3A4);
        end
        check("r4_done_pulses", done_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_load_arb.md
# mem_load_arb

Data-port arbiter and serial program loader for the 8 KB unified memory array. In normal operation it passes the CPU data-port address, write data and byte enables straight through to the memory. On a load request it takes ownership of the data port and holds the core in reset. It then assembles a big-endian byte stream from the UART receiver into 32-bit words, writes them to consecutive word addresses, and releases the core once the image is complete.

## Interface

Parameters:
- LOAD_WORDS, 2048: number of words per load session (8 KB image); legal range 1..65535.
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word; bits [1:0] must be 0.
- RELEASE_CYC, 4: number of cycles core_rst_o stays high after the last write; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- ld_start  in  1  one-cycle request to begin a load session; sampled only in IDLE.
- ld_byte_i  in  8  received byte.
- ld_byte_vld  in  1  one-cycle strobe that qualifies ld_byte_i.
- core_addr_i  in  32  CPU data address.
- core_dout_i  in  32  CPU write data.
- core_wr_en_i  in  4  CPU byte write enables.
- mem_addr_o  out  32  address to the memory array, driving both rd_addr and wr_addr.
- mem_din_o  out  32  write data to the memory array.
- mem_wr_en_o  out  4  byte write enables to the memory array.
- core_rst_o  out  1  active-high hold reset for the CPU; the top level ORs it with the system reset.
- ld_busy_o  out  1  high in any state other than IDLE.
- ld_done_o  out  1  one-cycle pulse when a session completes.
- ld_cnt_o  out  16  number of words written in the current or last session.

## Operation

- States: IDLE, LOAD, RELEASE.
- IDLE:
  - mem_addr_o = core_addr_i, mem_din_o = core_dout_i, mem_wr_en_o = core_wr_en_i. These are combinational with zero latency.
  - core_rst_o = 0.
  - ld_byte_vld is ignored.
  - When ld_start = 1 at an edge, go to LOAD. At the same edge, clear ld_cnt_o, the byte index and the pending flag.
- LOAD:
  - core_rst_o = 1 and core inputs are ignored.
  - Each ld_byte_vld shifts ld_byte_i into the assembly register. The first byte of a word lands in [31:24], the fourth in [7:0], and the byte index wraps 3 -> 0.
  - On the 4th byte:
    - copy the assembly register into the write register;
    - set pend = 1.
  - The assembly register is independent of the write register, so a byte arriving in a write cycle is never lost.
  - While pend = 1, for exactly one cycle:
    - mem_wr_en_o = 4'hF;
    - mem_din_o = write register;
    - mem_addr_o = BASE_ADDR + 4*ld_cnt_o.
  - At the end of that cycle, clear pend and increment ld_cnt_o.
  - In all other LOAD/RELEASE cycles, mem_wr_en_o = 4'h0, mem_addr_o holds the last load address, and mem_din_o holds the write register.
  - At the edge that ends the write of word LOAD_WORDS, go to RELEASE and load the release counter with RELEASE_CYC.
- RELEASE:
  - core_rst_o = 1 and ld_byte_vld is ignored.
  - The release counter decrements each cycle.
  - At the edge where it reaches 0, go to IDLE and pulse ld_done_o for one cycle. ld_done_o is registered, so it is high during the first IDLE cycle.
- ld_start outside IDLE is ignored, with no restart.
- ld_cnt_o holds its final value in IDLE until the next ld_start.
- Partial word at reset: discarded, never written.
- Reset values (asynchronous, while rst = 0):
  - state IDLE;
  - core_rst_o = 0, ld_busy_o = 0, ld_done_o = 0, ld_cnt_o = 0;
  - pend = 0, byte index 0;
  - assembly and write registers 0.
  - The mem_* outputs follow the core inputs during reset because of the IDLE passthrough.
- Reset mid-LOAD or mid-RELEASE: no further memory writes occur and the core is returned to the system reset only.

## Timing

- Passthrough in IDLE: 0 cycles.
- Takeover: ld_start is sampled at edge E. From cycle E+1, core_rst_o = 1 and the mux selects the loader.
- Write latency: the 4th byte is sampled at edge N. mem_wr_en_o = 4'hF during cycle N..N+1, and the memory captures the word at edge N+1.
- Bytes may arrive on every cycle. The maximum sustained rate is 1 byte/cycle, with one write per 4 cycles and no back-pressure.
- Release: the last write edge is L. core_rst_o falls and ld_done_o rises at edge L+RELEASE_CYC.
- ld_busy_o is registered and equals (state != IDLE).

## Test plan

- Reset: hold rst = 0 with random core inputs.
  - All outputs must be at their reset values.
  - mem_* must track the core inputs.
  - No write may occur while core_wr_en_i = 0.
- Passthrough: in IDLE, drive core_addr_i = 32'h0000_0100, core_dout_i = 32'hDEAD_BEEF, core_wr_en_i = 4'b0011.
  - mem_* must equal these inputs in the same cycle.
  - core_rst_o must be 0.
- Load with LOAD_WORDS = 2, bytes 12 34 56 78 9A BC DE F0 spaced 3 cycles apart:
  - write addr 0 = 32'h1234_5678, then addr 4 = 32'h9ABC_DEF0, each with wr_en 4'hF for exactly one cycle;
  - core_rst_o high for the whole session plus 4 cycles after the last write;
  - ld_done_o pulses once; ld_cnt_o = 2.
- Back-to-back bytes on every cycle, with the 5th byte arriving in the write cycle:
  - second word assembled correctly;
  - no dropped byte.
- ld_start re-pulsed mid-LOAD: ignored; the address sequence and ld_cnt_o continue unchanged.
- rst asserted after 6 bytes:
  - immediately IDLE, core_rst_o = 0, ld_cnt_o = 0;
  - only word 0 has been written; the partial word is not written.
